vga_timing_core: RTL and testbench
==================================

// Module: vga_timing_core
// PURPOSE
//  Parametrised VGA raster timing generator; replaces the fixed 640x480 controller and its toggle divider.
//  Derives a pixel-enable strobe from clk, runs H/V counters and emits hsync/vsync/blank_b.
//  Sync/blank are delayed DLY pixels, so a multi-cycle pixel pipeline (board/piece renderer) stays aligned.
//  Emits frame/line strobes for game-state double-buffer swaps.
// PARAMETERS
//  CLK_DIV    2    clk cycles per pixel (>=1; 1 => pix_en constantly high)
//  HACTIVE    640  visible pixels per line
//  HFP        16   horizontal front porch (pixels)
//  HSYN       96   hsync pulse width (pixels)
//  HBP        48   horizontal back porch (pixels)
//  VACTIVE    480  visible lines
//  VFP        11   vertical front porch (lines)
//  VSYN       2    vsync pulse width (lines)
//  VBP        32   vertical back porch (lines)
//  HSYNC_POL  0    asserted level of hsync (0 = active low)
//  VSYNC_POL  0    asserted level of vsync
//  DLY        0    pixel-tick delay on sync/blank outputs (0..7)
//  FCW        8    frame counter width
// PORTS
//  clk          in   1    system clock
//  reset        in   1    asynchronous, active-high reset
//  pix_en       out  1    one-clk pixel strobe; all counters advance only when high
//  x            out  CW   current column, CW = $clog2(HMAX), HMAX = HACTIVE+HFP+HSYN+HBP
//  y            out  RW   current line, RW = $clog2(VMAX), VMAX = VACTIVE+VFP+VSYN+VBP
//  hsync        out  1    horizontal sync, delayed DLY ticks
//  vsync        out  1    vertical sync, delayed DLY ticks
//  blank_b      out  1    1 = visible pixel, delayed DLY ticks
//  sync_b       out  1    constant 0 (composite sync unused)
//  frame_start  out  1    one-clk pulse with pix_en at x==0 and y==0 (undelayed)
//  line_start   out  1    one-clk pulse with pix_en at x==0, on every line
//  frame_cnt    out  FCW  frame counter; see CONFIGURATION
// BEHAVIOUR
//  - Reset values: div_cnt=0, pix_en=0, x=0, y=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL,
//    blank_b=0, frame_start=0, line_start=0, frame_cnt=0. The delay line clears to inactive values.
//  - Divider: div_cnt counts 0..CLK_DIV-1. pix_en is registered, high for 1 clk when div_cnt==CLK_DIV-1.
//    With CLK_DIV=2, the first pix_en occurs on clk edge 2 after reset release.
//  - On pix_en: x increments and wraps HMAX-1 -> 0. On that wrap, y increments and wraps VMAX-1 -> 0.
//    There is no HMAX/VMAX count state: exactly HMAX ticks per line and VMAX lines per frame.
//  - Raw hsync asserted for HACTIVE+HFP <= x < HACTIVE+HFP+HSYN.
//  - Raw vsync asserted for VACTIVE+VFP <= y < VACTIVE+VFP+VSYN.
//  - Raw blank_b = (x < HACTIVE) & (y < VACTIVE).
//  - Raw {hsync, vsync, blank_b} pass through a DLY-stage shift register clocked by pix_en.
//    DLY=0 gives combinational-from-counter outputs. x/y are never delayed.
//  - frame_start/line_start are decoded from the counter values being presented.
//    They are high only on the clk where pix_en is high.
//  - Reset mid-frame: all state returns to reset values immediately (async). Counting resumes at x=0, y=0.
//  - All arithmetic is unsigned and truncated to CW/RW. Parameter sums must fit these widths.
//    Static assertion: CLK_DIV>=1, DLY<=7.
// CONFIGURATION
//  VGA_FRAME_CNT_EN defined:
//    frame_cnt increments by 1 on each frame_start and wraps 2^FCW-1 -> 0.
//    The first frame_start after reset takes frame_cnt 0 -> 1.
//  VGA_FRAME_CNT_EN undefined:
//    frame_cnt tied to 0; no counter flops are generated.
// STRUCTURE
//  - Package vga_pkg: default 640x480 timing constants, rgb_t (3x8-bit) typedef, sync_bus_t struct {hsync,vsync,blank_b}.
//  - Sub-module vga_sync_delay: parametrised DEPTH x sync_bus_t shift register with enable and async reset-to-inactive.
//    DEPTH=0 is a pass-through.
// TESTING
//  1. Defaults, reset 3 clks then release
//     -> pix_en high on clk 2,4,6...; x=1 after first pix_en; frame_start at first pix_en.
//  2. One full line
//     -> hsync low exactly for x=656..751 (96 ticks); blank_b high for x=0..639 on y<480; x wraps 799 -> 0; y steps 0 -> 1.
//  3. Full frame
//     -> vsync low for y=491..492; blank_b=0 for y>=480; 420000 pix_en between frame_starts; y wraps 524 -> 0.
//  4. DLY=3, CLK_DIV=1
//     -> hsync falls 3 clks after x reaches 656; blank_b falls 3 clks after x=640.
//  5. Assert reset at x=300, y=200 mid-line
//     -> x=0, y=0, pix_en=0 and syncs inactive in same cycle; restart matches scenario 1.
//  6. VGA_FRAME_CNT_EN, FCW=2, run 5 frames
//     -> frame_cnt sequence 1,2,3,0,1. Without macro: frame_cnt stays 0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA raster timing blocks.
// Holds the default 640x480@60 timing, the pixel colour type and the
// bundle of sync/blank signals that travels through the output delay line.
package vga_pkg;

  // Default 640x480 timing, in pixels (horizontal) and lines (vertical)
  localparam int unsigned DEF_CLK_DIV = 2;
  localparam int unsigned DEF_HACTIVE = 640;
  localparam int unsigned DEF_HFP     = 16;
  localparam int unsigned DEF_HSYN    = 96;
  localparam int unsigned DEF_HBP     = 48;
  localparam int unsigned DEF_VACTIVE = 480;
  localparam int unsigned DEF_VFP     = 11;
  localparam int unsigned DEF_VSYN    = 2;
  localparam int unsigned DEF_VBP     = 32;

  // Longest supported sync/blank delay, in pixel ticks
  localparam int unsigned MAX_DLY = 7;

  // One pixel colour as produced by the renderer
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Sync/blank bundle; hsync/vsync carry their final (polarity-applied) level
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic blank_b;
  } sync_bus_t;

  // Level of the bundle when nothing is being shown: syncs idle, blanked
  function automatic sync_bus_t sync_idle(input bit hpol, input bit vpol);
    sync_bus_t s;
    s.hsync   = ~hpol;
    s.vsync   = ~vpol;
    s.blank_b = 1'b0;
    return s;
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Shift register that delays the sync/blank bundle by DEPTH pixel ticks so it
// lines up with a multi-cycle pixel pipeline. Advances only when en is high.
// Reset clears every stage to the idle bundle (syncs inactive, blanked).
// DEPTH = 0 is a plain wire.
module vga_sync_delay
  import vga_pkg::*;
#(
  parameter int unsigned DEPTH     = 0,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      en,
  input  sync_bus_t din,
  output sync_bus_t dout
);

  localparam sync_bus_t IDLE = sync_idle(HSYNC_POL, VSYNC_POL);

  if (DEPTH == 0) begin : g_pass
    // No storage: clock, reset and enable have no effect here
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, reset, en};
    assign dout = din;
  end else begin : g_shift
    sync_bus_t stage [DEPTH];

    // Shift one position per pixel tick; async reset to the idle bundle
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          stage[i] <= IDLE;
        end
      end else if (en) begin
        stage[0] <= din;
        for (int i = 1; i < int'(DEPTH); i++) begin
          stage[i] <= stage[i-1];
        end
      end
    end

    assign dout = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_core.sv
// Parametrised VGA raster timing generator.
// A clock divider produces a one-clk pixel strobe (pix_en); H/V counters step
// on that strobe and sync/blank are decoded from them, then delayed DLY pixel
// ticks so a pipelined renderer stays aligned. x/y and the frame/line strobes
// are never delayed.
// Build option: define VGA_FRAME_CNT_EN to get a free-running frame counter on
// frame_cnt; without it frame_cnt is tied to zero and no counter is built.
module vga_timing_core
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
  parameter int unsigned HACTIVE   = DEF_HACTIVE,
  parameter int unsigned HFP       = DEF_HFP,
  parameter int unsigned HSYN      = DEF_HSYN,
  parameter int unsigned HBP       = DEF_HBP,
  parameter int unsigned VACTIVE   = DEF_VACTIVE,
  parameter int unsigned VFP       = DEF_VFP,
  parameter int unsigned VSYN      = DEF_VSYN,
  parameter int unsigned VBP       = DEF_VBP,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0,
  parameter int unsigned DLY       = 0,
  parameter int unsigned FCW       = 8,
  localparam int unsigned HMAX     = HACTIVE + HFP + HSYN + HBP,
  localparam int unsigned VMAX     = VACTIVE + VFP + VSYN + VBP,
  localparam int unsigned CW       = $clog2(HMAX),
  localparam int unsigned RW       = $clog2(VMAX)
) (
  input  logic           clk,
  input  logic           reset,
  output logic           pix_en,
  output logic [CW-1:0]  x,
  output logic [RW-1:0]  y,
  output logic           hsync,
  output logic           vsync,
  output logic           blank_b,
  output logic           sync_b,
  output logic           frame_start,
  output logic           line_start,
  output logic [FCW-1:0] frame_cnt
);

  // Elaboration-time parameter checks
  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("vga_timing_core: CLK_DIV must be at least 1");
  end
  if (DLY > MAX_DLY) begin : g_bad_dly
    $error("vga_timing_core: DLY must be in 0..7");
  end

  localparam int unsigned DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);
  localparam logic [CW-1:0]   X_LAST   = CW'(HMAX - 1);
  localparam logic [RW-1:0]   Y_LAST   = RW'(VMAX - 1);

  // Sync windows as half-open ranges [start, end), compared at 32 bits so an
  // end that equals 2**CW cannot wrap
  localparam int unsigned H_SYNC_START = HACTIVE + HFP;
  localparam int unsigned H_SYNC_END   = HACTIVE + HFP + HSYN;
  localparam int unsigned V_SYNC_START = VACTIVE + VFP;
  localparam int unsigned V_SYNC_END   = VACTIVE + VFP + VSYN;

  logic [DIVW-1:0] div_cnt;
  logic            run;
  logic            hs_on;
  logic            vs_on;
  logic            visible;
  sync_bus_t       raw_sync;
  sync_bus_t       dly_sync;

  // Clock divider: pix_en is a registered one-clk strobe when div_cnt wraps
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      pix_en  <= 1'b0;
    end else begin
      pix_en <= (div_cnt == DIV_LAST);
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + DIVW'(1);
      end
    end
  end

  // Raster counters: x wraps at HMAX-1, y steps on each x wrap and wraps at VMAX-1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (pix_en) begin
      if (x == X_LAST) begin
        x <= '0;
        if (y == Y_LAST) begin
          y <= '0;
        end else begin
          y <= y + RW'(1);
        end
      end else begin
        x <= x + CW'(1);
      end
    end
  end

  // Goes high on the first clk after reset; keeps blank_b low while reset is
  // held, since x=y=0 would otherwise decode as a visible pixel when DLY=0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run <= 1'b0;
    end else begin
      run <= 1'b1;
    end
  end

  // Decode raw sync/blank from the counter position being presented
  always_comb begin
    hs_on   = (32'(x) >= H_SYNC_START) && (32'(x) < H_SYNC_END);
    vs_on   = (32'(y) >= V_SYNC_START) && (32'(y) < V_SYNC_END);
    visible = (32'(x) < HACTIVE) && (32'(y) < VACTIVE);
    raw_sync.hsync   = HSYNC_POL ? hs_on : ~hs_on;
    raw_sync.vsync   = VSYNC_POL ? vs_on : ~vs_on;
    raw_sync.blank_b = run & visible;
  end

  vga_sync_delay #(
    .DEPTH     (DLY),
    .HSYNC_POL (HSYNC_POL),
    .VSYNC_POL (VSYNC_POL)
  ) u_sync_delay (
    .clk   (clk),
    .reset (reset),
    .en    (pix_en),
    .din   (raw_sync),
    .dout  (dly_sync)
  );

  assign hsync   = dly_sync.hsync;
  assign vsync   = dly_sync.vsync;
  assign blank_b = dly_sync.blank_b;
  assign sync_b  = 1'b0;

  // Strobes qualify the undelayed counters with pix_en so they last one clk
  assign line_start  = pix_en & (x == '0);
  assign frame_start = line_start & (y == '0);

`ifdef VGA_FRAME_CNT_EN
  // Count frames; first frame_start after reset takes the count to 1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (frame_start) begin
      frame_cnt <= frame_cnt + FCW'(1);
    end
  end
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_timing_core.sv
`timescale 1ns/1ps
module tb_vga_timing_core;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: default timing
  logic       pe_def, hs_def, vs_def, bl_def, sb_def, fs_def, ls_def;
  logic [9:0] x_def, y_def;
  logic [7:0] fc_def;
  // Instance 1: CLK_DIV=1, DLY=3, default raster
  logic       pe_d3, hs_d3, vs_d3, bl_d3, sb_d3, fs_d3, ls_d3;
  logic [9:0] x_d3, y_d3;
  logic [7:0] fc_d3;
  // Instance 2: tiny raster (15x11), CLK_DIV=3, positive syncs, DLY=2, FCW=2
  logic       pe_sm, hs_sm, vs_sm, bl_sm, sb_sm, fs_sm, ls_sm;
  logic [3:0] x_sm, y_sm;
  logic [1:0] fc_sm;

  vga_timing_core u_def (
    .clk(clk), .reset(reset), .pix_en(pe_def), .x(x_def), .y(y_def),
    .hsync(hs_def), .vsync(vs_def), .blank_b(bl_def), .sync_b(sb_def),
    .frame_start(fs_def), .line_start(ls_def), .frame_cnt(fc_def));

  vga_timing_core #(.CLK_DIV(1), .DLY(3)) u_d3 (
    .clk(clk), .reset(reset), .pix_en(pe_d3), .x(x_d3), .y(y_d3),
    .hsync(hs_d3), .vsync(vs_d3), .blank_b(bl_d3), .sync_b(sb_d3),
    .frame_start(fs_d3), .line_start(ls_d3), .frame_cnt(fc_d3));

  vga_timing_core #(.CLK_DIV(3), .HACTIVE(8), .HFP(2), .HSYN(3), .HBP(2),
                    .VACTIVE(6), .VFP(1), .VSYN(2), .VBP(2),
                    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .DLY(2), .FCW(2)) u_sm (
    .clk(clk), .reset(reset), .pix_en(pe_sm), .x(x_sm), .y(y_sm),
    .hsync(hs_sm), .vsync(vs_sm), .blank_b(bl_sm), .sync_b(sb_sm),
    .frame_start(fs_sm), .line_start(ls_sm), .frame_cnt(fc_sm));

  typedef struct {
    int div, ha, hf, hs, hb, va, vf, vs, vb;
    bit hp, vp;
    int dly, fcw;
  } cfg_t;

  typedef struct {
    logic        pix_en;
    logic [31:0] x;
    logic [31:0] y;
    logic        hsync;
    logic        vsync;
    logic        blank_b;
    logic        fs;
    logic        ls;
    logic [31:0] fc;
  } obs_t;

  typedef struct {
    int   inst;
    int   kk;
    logic pe;
    int   x;
    int   y;
    logic hs;
    logic bl;
    logic fs;
  } vec_t;

  cfg_t c_def = '{2, 640, 16, 96, 48, 480, 11, 2, 32, 1'b0, 1'b0, 0, 8};
  cfg_t c_d3  = '{1, 640, 16, 96, 48, 480, 11, 2, 32, 1'b0, 1'b0, 3, 8};
  cfg_t c_sm  = '{3, 8, 2, 3, 2, 6, 1, 2, 2, 1'b1, 1'b1, 2, 2};

  int n_cmp = 0;
  int n_bad = 0;
  int k = 0;   // posedges since reset release

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (k=%0d, t=%0t)", name, act, exp, k, $time);
    end
  endtask

  // Reference model: everything follows from the number of clk edges since
  // reset release. Pixel tick t counts completed pix_en strobes; sync/blank
  // show the raster position of tick t-DLY (idle before it exists).
  function automatic obs_t model(input cfg_t c, input int kk);
    obs_t r;
    int hmax, vmax, fr, t, s, sx, sy;
    logic hon, von;
    hmax = c.ha + c.hf + c.hs + c.hb;
    vmax = c.va + c.vf + c.vs + c.vb;
    fr   = hmax * vmax;
    r.pix_en = 1'b0; r.x = 0; r.y = 0; r.fs = 1'b0; r.ls = 1'b0; r.fc = 0;
    r.hsync = ~c.hp; r.vsync = ~c.vp; r.blank_b = 1'b0;
    if (kk == 0) return r;
    t = (kk - 1) / c.div;
    r.pix_en = ((kk % c.div) == 0);
    r.x = t % hmax;
    r.y = (t / hmax) % vmax;
    s = t - c.dly;
    if (s >= 0) begin
      sx = s % hmax;
      sy = (s / hmax) % vmax;
      hon = (sx >= c.ha + c.hf) && (sx < c.ha + c.hf + c.hs);
      von = (sy >= c.va + c.vf) && (sy < c.va + c.vf + c.vs);
      r.hsync = hon ? c.hp : ~c.hp;
      r.vsync = von ? c.vp : ~c.vp;
      r.blank_b = (sx < c.ha) && (sy < c.va);
    end
    r.ls = r.pix_en && (r.x == 0);
    r.fs = r.ls && (r.y == 0);
`ifdef VGA_FRAME_CNT_EN
    r.fc = ((t + fr - 1) / fr) % (1 << c.fcw);
`endif
    return r;
  endfunction

  task automatic cmp_obs(input string inst, input obs_t o, input obs_t e);
    chk({inst, ".pix_en"},      o.pix_en,  e.pix_en);
    chk({inst, ".x"},           o.x,       e.x);
    chk({inst, ".y"},           o.y,       e.y);
    chk({inst, ".hsync"},       o.hsync,   e.hsync);
    chk({inst, ".vsync"},       o.vsync,   e.vsync);
    chk({inst, ".blank_b"},     o.blank_b, e.blank_b);
    chk({inst, ".frame_start"}, o.fs,      e.fs);
    chk({inst, ".line_start"},  o.ls,      e.ls);
    chk({inst, ".frame_cnt"},   o.fc,      e.fc);
  endtask

  task automatic check_all();
    obs_t o;
    o = '{pe_def, 32'(x_def), 32'(y_def), hs_def, vs_def, bl_def, fs_def, ls_def, 32'(fc_def)};
    cmp_obs("def", o, model(c_def, k));
    o = '{pe_d3, 32'(x_d3), 32'(y_d3), hs_d3, vs_d3, bl_d3, fs_d3, ls_d3, 32'(fc_d3)};
    cmp_obs("d3", o, model(c_d3, k));
    o = '{pe_sm, 32'(x_sm), 32'(y_sm), hs_sm, vs_sm, bl_sm, fs_sm, ls_sm, 32'(fc_sm)};
    cmp_obs("sm", o, model(c_sm, k));
    chk("sync_b", {sb_def, sb_d3, sb_sm}, 0);
  endtask

  // One clk: advance, then sample on the falling edge
  task automatic step();
    @(posedge clk);
    if (!reset) k++;
    @(negedge clk);
    check_all();
  endtask

  task automatic apply_vec(input vec_t v);
    if (v.inst == 0) begin
      chk("vec.def.pix_en", pe_def, v.pe);
      chk("vec.def.x", x_def, v.x);
      chk("vec.def.y", y_def, v.y);
      chk("vec.def.hsync", hs_def, v.hs);
      chk("vec.def.blank_b", bl_def, v.bl);
      chk("vec.def.frame_start", fs_def, v.fs);
    end else begin
      chk("vec.d3.pix_en", pe_d3, v.pe);
      chk("vec.d3.x", x_d3, v.x);
      chk("vec.d3.y", y_d3, v.y);
      chk("vec.d3.hsync", hs_d3, v.hs);
      chk("vec.d3.blank_b", bl_d3, v.bl);
      chk("vec.d3.frame_start", fs_d3, v.fs);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[$];
    int   fc_log[$];
    int   fc_exp[5];
    int   last_fs, pe_cnt_sm, hs_low, bl_hi;
    bit   fc_pending, found;

    // inst, clk edge, pix_en, x, y, hsync, blank_b, frame_start
    vecs.push_back('{0,    1, 1'b0,   0, 0, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{0,    2, 1'b1,   0, 0, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{0,    3, 1'b0,   1, 0, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{0, 1279, 1'b0, 639, 0, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{0, 1281, 1'b0, 640, 0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{0, 1311, 1'b0, 655, 0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{0, 1313, 1'b0, 656, 0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{0, 1503, 1'b0, 751, 0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{0, 1505, 1'b0, 752, 0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{0, 1600, 1'b1, 799, 0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{0, 1601, 1'b0,   0, 1, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{0, 1602, 1'b1,   0, 1, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1,    1, 1'b1,   0, 0, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1,    4, 1'b1,   3, 0, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1,  643, 1'b1, 642, 0, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1,  644, 1'b1, 643, 0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1,  659, 1'b1, 658, 0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1,  660, 1'b1, 659, 0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1,  755, 1'b1, 754, 0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1,  756, 1'b1, 755, 0, 1'b1, 1'b0, 1'b0});

`ifdef VGA_FRAME_CNT_EN
    fc_exp = '{1, 2, 3, 0, 1};
`else
    fc_exp = '{0, 0, 0, 0, 0};
`endif

    // Power-on reset, held 3 clks
    #2 reset = 1'b1;
    k = 0;
    repeat (3) step();
    reset = 1'b0;

    // Phase 1: first two lines of the default raster, several tiny frames
    last_fs = -1; pe_cnt_sm = 0; hs_low = 0; bl_hi = 0; fc_pending = 1'b0;
    for (int c = 0; c < 3400; c++) begin
      step();
      foreach (vecs[i]) if (vecs[i].kk == k) apply_vec(vecs[i]);
      if (fc_pending) begin
        fc_log.push_back(int'(fc_sm));
        fc_pending = 1'b0;
      end
      if (fs_sm) begin
        if (last_fs >= 0) chk("sm.pix_per_frame", pe_cnt_sm - last_fs, 165);
        last_fs = pe_cnt_sm;
        fc_pending = 1'b1;
      end
      if (pe_sm) pe_cnt_sm++;
      if (k <= 1600 && pe_def) begin
        if (!hs_def) hs_low++;
        if (bl_def) bl_hi++;
      end
    end
    chk("def.hsync_low_ticks_line0", hs_low, 96);
    chk("def.blank_high_ticks_line0", bl_hi, 640);
    chk("sm.frames_logged", (fc_log.size() >= 5), 1);
    for (int i = 0; i < 5; i++) begin
      if (i < fc_log.size()) chk($sformatf("sm.frame_cnt_seq[%0d]", i), fc_log[i], fc_exp[i]);
    end

    // Phase 2: async reset mid-frame on the tiny raster, away from any edge
    found = 1'b0;
    for (int c = 0; c < 2000 && !found; c++) begin
      step();
      if (x_sm == 4'd5 && y_sm == 4'd4) found = 1'b1;
    end
    chk("wait_sm_x5_y4", found, 1);
    #2 reset = 1'b1;
    k = 0;
    #1;
    check_all();
    chk("midreset.def.pix_en", pe_def, 0);
    chk("midreset.def.x", x_def, 0);
    chk("midreset.sm.hsync_idle", hs_sm, 0);
    chk("midreset.sm.blank_b", bl_sm, 0);
    repeat (2) step();
    reset = 1'b0;
    step();
    chk("restart.def.pix_en_edge1", pe_def, 0);
    step();
    chk("restart.def.frame_start_edge2", fs_def, 1);
    step();
    chk("restart.def.x_after_first_tick", x_def, 1);
    repeat (40) step();

    // Phase 3: random run lengths with random asynchronous reset pulses
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(3000, 20);
      repeat (n) step();
      #($urandom_range(3, 1)) reset = 1'b1;
      k = 0;
      #1;
      check_all();
      repeat ($urandom_range(3, 1)) step();
      reset = 1'b0;
    end
    repeat ($urandom_range(1200, 600)) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
